// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and encodings for the instruction-fetch stage.
//   pc_sel_e   : redirect-source encoding carried on id_if_selpctype
//   NOP_INSTR  : bubble word inserted on redirect when FETCH_FLUSH_EN is defined
//   PC_INCR    : sequential PC step (one 32-bit word)
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    PCSEL_IMD2EXT = 2'b00,
    PCSEL_REGA    = 2'b01,
    PCSEL_INDEX   = 2'b10,
    PCSEL_EXC     = 2'b11
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  // Sequential successor; 32-bit addition wraps 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/fetch_pc_mux.sv
// -----------------------------------------------------------------------------
// fetch_pc_mux
// Combinational next-PC selection for the fetch stage. Stall and reset
// priority live in the parent; this block only answers "where would the PC
// go if the stage advanced this cycle".
//
// Ports
//   pc_plus4     in  32  sequential successor of the current PC
//   selpcsource  in   1  1 = take a redirect target, 0 = sequential
//   selpctype    in   2  redirect source (see fetch_pkg::pc_sel_e)
//   rega         in  32  register-jump target
//   pcimd2ext    in  32  PC-relative branch target
//   pcindex      in  32  absolute jump target
//   pc_next      out 32  selected next PC
//
// Parameters
//   EXC_VECTOR   target used for PCSEL_EXC
// -----------------------------------------------------------------------------
module fetch_pc_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'd64
) (
  input  logic [31:0] pc_plus4,
  input  logic        selpcsource,
  input  logic [1:0]  selpctype,
  input  logic [31:0] rega,
  input  logic [31:0] pcimd2ext,
  input  logic [31:0] pcindex,
  output logic [31:0] pc_next
);

  logic [31:0] redirect_target;

  // Targets pass through unaltered; no alignment is enforced here.
  always_comb begin
    redirect_target = pcimd2ext;
    case (pc_sel_e'(selpctype))
      PCSEL_IMD2EXT: redirect_target = pcimd2ext;
      PCSEL_REGA:    redirect_target = rega;
      PCSEL_INDEX:   redirect_target = pcindex;
      PCSEL_EXC:     redirect_target = EXC_VECTOR;
      default:       redirect_target = pcimd2ext;
    endcase
  end

  always_comb begin
    pc_next = selpcsource ? redirect_target : pc_plus4;
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage 32-bit pipeline. Holds the PC,
// issues a combinational read to the memory controller at the PC, and
// captures the returned word plus PC+4 into the IF/ID register.
//
// Ports
//   clock              in   1  system clock, rising edge
//   reset              in   1  synchronous, active-high
//   ex_if_stall        in   1  freeze PC and IF/ID register
//   id_if_selpcsource  in   1  1 = redirect using id_if_selpctype
//   id_if_selpctype    in   2  00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR
//   id_if_rega         in  32  register-jump target
//   id_if_pcimd2ext    in  32  branch target
//   id_if_pcindex      in  32  jump target
//   mc_if_data         in  32  instruction word at if_mc_addr (same cycle)
//   if_mc_en           out  1  memory read enable
//   if_mc_addr         out 32  memory read address (= pc)
//   if_id_nextpc       out 32  registered PC+4 of fetched instruction
//   if_id_instruc      out 32  registered fetched instruction
//
// Parameters
//   RESET_PC    PC loaded on reset
//   EXC_VECTOR  exception redirect target
//
// Build option
//   FETCH_FLUSH_EN  when defined, the word fetched in a redirect cycle is
//                   replaced by a NOP bubble; otherwise it passes through as
//                   the branch delay slot.
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'd64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_if_stall,
  input  logic        id_if_selpcsource,
  input  logic [1:0]  id_if_selpctype,
  input  logic [31:0] id_if_rega,
  input  logic [31:0] id_if_pcimd2ext,
  input  logic [31:0] id_if_pcindex,
  input  logic [31:0] mc_if_data,
  output logic        if_mc_en,
  output logic [31:0] if_mc_addr,
  output logic [31:0] if_id_nextpc,
  output logic [31:0] if_id_instruc
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr_capture;

  assign pc_plus4 = pc_step(pc);

  fetch_pc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_mux (
    .pc_plus4    (pc_plus4),
    .selpcsource (id_if_selpcsource),
    .selpctype   (id_if_selpctype),
    .rega        (id_if_rega),
    .pcimd2ext   (id_if_pcimd2ext),
    .pcindex     (id_if_pcindex),
    .pc_next     (pc_next)
  );

`ifdef FETCH_FLUSH_EN
  always_comb begin
    instr_capture = id_if_selpcsource ? NOP_INSTR : mc_if_data;
  end
`else
  always_comb begin
    instr_capture = mc_if_data;
  end
`endif

  // Reset beats stall; stall beats redirect (decode re-presents it later).
  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_PC;
      if_id_nextpc  <= 32'h0000_0000;
      if_id_instruc <= 32'h0000_0000;
    end else if (!ex_if_stall) begin
      pc            <= pc_next;
      if_id_nextpc  <= pc_plus4;
      if_id_instruc <= instr_capture;
    end
  end

  assign if_mc_addr = pc;
  assign if_mc_en   = !reset && !ex_if_stall;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] EXC = 32'd64;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_if_stall;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_pcindex;
  logic [31:0] mc_if_data;
  logic        if_mc_en;
  logic [31:0] if_mc_addr;
  logic [31:0] if_id_nextpc;
  logic [31:0] if_id_instruc;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_np, m_ins;
  bit          model_on = 0;

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock             (clock),
    .reset             (reset),
    .ex_if_stall       (ex_if_stall),
    .id_if_selpcsource (id_if_selpcsource),
    .id_if_selpctype   (id_if_selpctype),
    .id_if_rega        (id_if_rega),
    .id_if_pcimd2ext   (id_if_pcimd2ext),
    .id_if_pcindex     (id_if_pcindex),
    .mc_if_data        (mc_if_data),
    .if_mc_en          (if_mc_en),
    .if_mc_addr        (if_mc_addr),
    .if_id_nextpc      (if_id_nextpc),
    .if_id_instruc     (if_id_instruc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_on) begin
      chk("mc_addr", if_mc_addr, m_pc);
      chk("mc_en", {31'd0, if_mc_en}, {31'd0, (!reset && !ex_if_stall)});
      chk("nextpc", if_id_nextpc, m_np);
      chk("instruc", if_id_instruc, m_ins);
    end
  end

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic cyc(input bit rst, input bit stall, input bit src, input logic [1:0] typ,
                     input logic [31:0] rega, input logic [31:0] imd,
                     input logic [31:0] idx, input logic [31:0] data);
    logic [31:0] tgt;
    reset = rst; ex_if_stall = stall; id_if_selpcsource = src; id_if_selpctype = typ;
    id_if_rega = rega; id_if_pcimd2ext = imd; id_if_pcindex = idx; mc_if_data = data;
    @(posedge clock);
    if (rst) begin
      m_pc = 32'h0; m_np = 32'h0; m_ins = 32'h0;
    end else if (!stall) begin
      if (!src)          tgt = m_pc + 32'd4;
      else if (typ == 0) tgt = imd;
      else if (typ == 1) tgt = rega;
      else if (typ == 2) tgt = idx;
      else               tgt = EXC;
      m_np = m_pc + 32'd4;
`ifdef FETCH_FLUSH_EN
      m_ins = src ? 32'h0 : data;
`else
      m_ins = data;
`endif
      m_pc = tgt;
    end
    model_on = 1;
    #1;
  endtask

  function automatic logic [31:0] redir_ins(input logic [31:0] data);
`ifdef FETCH_FLUSH_EN
    return 32'h0;
`else
    return data;
`endif
  endfunction

  initial begin
    logic [31:0] held_np, held_ins;
    reset = 1; ex_if_stall = 0; id_if_selpcsource = 0; id_if_selpctype = 0;
    id_if_rega = 0; id_if_pcimd2ext = 0; id_if_pcindex = 0; mc_if_data = 0;

    // Reset then run
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hDEAD);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hBEEF);
    chk("rst_addr", if_mc_addr, 32'h0);
    chk("rst_en", {31'd0, if_mc_en}, 32'd0);
    chk("rst_ins", if_id_instruc, 32'h0);
    chk("rst_np", if_id_nextpc, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hA0);
    chk("run_ins0", if_id_instruc, 32'hA0);
    chk("run_np0", if_id_nextpc, 32'd4);
    chk("run_addr1", if_mc_addr, 32'd4);
    chk("run_en", {31'd0, if_mc_en}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hA1);
    chk("run_ins1", if_id_instruc, 32'hA1);
    chk("run_np1", if_id_nextpc, 32'd8);
    chk("run_addr2", if_mc_addr, 32'd8);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hA2);
    chk("run_addr3", if_mc_addr, 32'd12);

    // Stall hold at pc = 12
    held_np = if_id_nextpc; held_ins = if_id_instruc;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, $urandom);
      chk("stall_addr", if_mc_addr, 32'd12);
      chk("stall_en", {31'd0, if_mc_en}, 32'd0);
      chk("stall_ins", if_id_instruc, 32'hA2);
      chk("stall_np", if_id_nextpc, 32'd12);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hA3);
    chk("release_addr", if_mc_addr, 32'd16);
    chk("release_ins", if_id_instruc, 32'hA3);
    chk("release_np", if_id_nextpc, 32'd16);

    // Redirect each selpctype
    cyc(0, 0, 1, 2'b00, 800, 1600, 3200, 32'hB0);
    chk("redir00_pc", if_mc_addr, 32'd1600);
    chk("redir00_np", if_id_nextpc, 32'd20);
    chk("redir00_ins", if_id_instruc, redir_ins(32'hB0));
    cyc(0, 0, 1, 2'b01, 800, 1600, 3200, 32'hB1);
    chk("redir01_pc", if_mc_addr, 32'd800);
    chk("redir01_np", if_id_nextpc, 32'd1604);
    cyc(0, 0, 1, 2'b10, 800, 1600, 3200, 32'hB2);
    chk("redir10_pc", if_mc_addr, 32'd3200);
    chk("redir10_np", if_id_nextpc, 32'd804);
    cyc(0, 0, 1, 2'b11, 800, 1600, 3200, 32'hB3);
    chk("redir11_pc", if_mc_addr, 32'd64);
    chk("redir11_np", if_id_nextpc, 32'd3204);
    chk("redir11_ins", if_id_instruc, redir_ins(32'hB3));

    // Stall together with redirect: redirect ignored, then re-presented
    cyc(0, 1, 1, 2'b01, 800, 1600, 3200, 32'hC0);
    chk("stallredir_pc", if_mc_addr, 32'd64);
    cyc(0, 0, 1, 2'b01, 800, 1600, 3200, 32'hC1);
    chk("after_stallredir_pc", if_mc_addr, 32'd800);

    // Wrap-around
    cyc(0, 0, 1, 2'b01, 32'hFFFF_FFFC, 0, 0, 32'hD0);
    chk("wrap_redir_pc", if_mc_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hD1);
    chk("wrap_pc", if_mc_addr, 32'h0);
    chk("wrap_np", if_id_nextpc, 32'h0);
    chk("wrap_ins", if_id_instruc, 32'hD1);

    // Unaligned redirect target passes through
    cyc(0, 0, 1, 2'b10, 0, 0, 32'h0000_1003, 32'hD2);
    chk("unaligned_pc", if_mc_addr, 32'h0000_1003);

    // Reset while stalled: reset wins
    cyc(0, 1, 0, 0, 0, 0, 0, 32'hE0);
    cyc(1, 1, 0, 0, 0, 0, 0, 32'hE1);
    chk("rst_stall_pc", if_mc_addr, 32'h0);
    chk("rst_stall_ins", if_id_instruc, 32'h0);

    // Randomised run against the model
    for (int i = 0; i < 400; i++) begin
      bit r, s, p;
      r = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) < 25);
      p = ($urandom_range(0, 99) < 25);
      cyc(r, s, p, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage 32-bit pipeline.
- Holds the program counter (PC) and drives the instruction-memory controller with a read request at the PC.
- Registers the returned instruction and PC+4 into the IF/ID pipeline register.
- Accepts PC redirects (branch/jump/exception) from decode and freezes on execute-stage stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'd64, redirect target when selpctype = 2'b11.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_if_stall  in  1  stall request from execute; 1 freezes the stage.
- id_if_selpcsource  in  1  1 = redirect PC using id_if_selpctype; 0 = sequential fetch.
- id_if_selpctype  in  2  redirect source: 00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR.
- id_if_rega  in  32  register-jump target (JR).
- id_if_pcimd2ext  in  32  branch target (PC-relative immediate).
- id_if_pcindex  in  32  jump target (J index).
- mc_if_data  in  32  instruction word from memory controller; valid in the same cycle as if_mc_addr (combinational read).
- if_mc_en  out  1  memory read enable.
- if_mc_addr  out  32  memory read address.
- if_id_nextpc  out  32  registered PC+4 of the fetched instruction.
- if_id_instruc  out  32  registered fetched instruction.

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous and active-high.
- State: pc (32b), if_id_nextpc (32b), if_id_instruc (32b).
- Combinational outputs:
  - if_mc_addr = pc.
  - if_mc_en = !reset && !ex_if_stall.
- Update priority per rising edge:
  1. reset = 1: pc <= RESET_PC; if_id_nextpc <= 0; if_id_instruc <= 0.
  2. ex_if_stall = 1: pc, if_id_nextpc and if_id_instruc all hold. mc_if_data is ignored. A simultaneous redirect is ignored; decode re-presents it after the stall.
  3. id_if_selpcsource = 1: pc <= target selected by id_if_selpctype. if_id_nextpc <= pc+4. if_id_instruc <= mc_if_data, unless FETCH_FLUSH_EN is defined (see below).
  4. Otherwise: pc <= pc+4; if_id_nextpc <= pc+4; if_id_instruc <= mc_if_data.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Redirect targets are used as-is (no alignment check; bits [1:0] pass through).
- Latency: instruction at address A appears on if_id_instruc one clock after pc = A, with if_id_nextpc = A+4.
- Reset mid-stall: reset wins. Release of stall resumes from the held pc with no lost or duplicated fetch.

Optional Feature:
- Macro: FETCH_FLUSH_EN.
- Defined: on a redirect edge (priority 3), if_id_instruc <= 32'h0000_0000 (NOP bubble) instead of mc_if_data. if_id_nextpc is still pc+4.
- Undefined: the instruction fetched in the redirect cycle passes through (MIPS branch-delay-slot semantics).

Decomposition:
- Shared package fetch_pkg:
  - PC-select encodings PCSEL_IMD2EXT = 2'b00, PCSEL_REGA = 2'b01, PCSEL_INDEX = 2'b10, PCSEL_EXC = 2'b11.
  - Constants NOP_INSTR = 32'h0 and PC_INCR = 4.
- Sub-module fetch_pc_mux: purely combinational next-PC selection from pc+4, the three targets and EXC_VECTOR, driven by selpcsource/selpctype. The top module holds the registers and the stall/reset priority.

Test Plan:
- Reset then run: reset held 2 cycles, then released with mc_if_data = 32'hA0, 32'hA1, ... -> if_mc_addr steps 0, 4, 8; if_id_instruc = A0 with if_id_nextpc = 4, then A1 with 8; if_mc_en = 0 during reset, 1 after.
- Stall hold: stall 5 cycles at pc = 12 while mc_if_data changes randomly -> if_mc_addr stays 12, if_mc_en = 0, IF/ID outputs unchanged; after release pc goes 12 -> 16.
- Redirect each selpctype with rega = 800, pcimd2ext = 1600, pcindex = 3200 -> next pc = 1600 (00), 800 (01), 3200 (10), 64 (11); if_id_nextpc = old pc+4.
- Simultaneous stall and redirect (selpctype 01) -> pc holds; on the following cycle with stall low, pc = rega.
- Wrap-around: redirect to 32'hFFFF_FFFC, then sequential -> pc = 0, if_id_nextpc = 0.
- With FETCH_FLUSH_EN defined, redirect cycle -> if_id_instruc = 0; without it -> if_id_instruc = mc_if_data.
